// File: rtl/bnn_fc_sched.sv
// Round-robin scheduler sharing one binary FC engine between NUM_REQ frame producers, one job in flight.
// Optional watchdog on the engine result: define BNN_FC_SCHED_WDOG_EN.
module bnn_fc_sched #(
  parameter int NUM_REQ     = 4,
  parameter int VEC_W       = 400,
  parameter int OUT_W       = 10,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*VEC_W-1:0]   req_vector,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       fc_in_valid,
  output logic [VEC_W-1:0]           fc_vector,
  input  logic                       fc_ready,
  input  logic                       fc_busy,
  input  logic                       fc_out_valid,
  input  logic [OUT_W-1:0]           fc_out_vector,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OUT_W-1:0]           res_vector,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic                       res_err,
  output logic [15:0]                jobs_done
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic            gnt_any;
  logic [ID_W-1:0] gnt_idx;
  logic            hit_hi;
  logic [ID_W-1:0] idx_hi;
  logic [ID_W-1:0] idx_lo;
  logic [ID_W-1:0] rr_next;

  // Lowest valid index at/after rr_ptr wins; otherwise wrap to the lowest valid index overall.
  always_comb begin
    hit_hi  = 1'b0;
    gnt_any = 1'b0;
    idx_hi  = '0;
    idx_lo  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_any = 1'b1;
        idx_lo  = ID_W'(k);
        if (ID_W'(k) >= rr_ptr) begin
          hit_hi = 1'b1;
          idx_hi = ID_W'(k);
        end
      end
    end
    gnt_idx = hit_hi ? idx_hi : idx_lo;
    rr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  end

  assign req_ready   = (state == S_IDLE && gnt_any) ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign fc_in_valid = (state == S_ISSUE) && fc_ready && !fc_busy;
  assign res_valid   = (state == S_RESP);

`ifdef BNN_FC_SCHED_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [CNT_W-1:0] wdog_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      fc_vector  <= '0;
      res_vector <= '0;
      res_id     <= '0;
      res_err    <= 1'b0;
      jobs_done  <= '0;
`ifdef BNN_FC_SCHED_WDOG_EN
      wdog_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            fc_vector <= req_vector[gnt_idx*VEC_W +: VEC_W];
            res_id    <= gnt_idx;
            rr_ptr    <= rr_next;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (fc_in_valid) begin
            state <= S_WAIT;
`ifdef BNN_FC_SCHED_WDOG_EN
            wdog_cnt <= CNT_W'(1);
`endif
          end
        end
        S_WAIT: begin
          if (fc_out_valid) begin
            res_vector <= fc_out_vector;
            res_err    <= 1'b0;
            state      <= S_RESP;
          end
`ifdef BNN_FC_SCHED_WDOG_EN
          // Counter holds cycles since issue; expiry lands res_valid exactly WDOG_CYCLES after issue.
          else if (wdog_cnt == CNT_W'(WDOG_CYCLES - 1)) begin
            res_vector <= '0;
            res_err    <= 1'b1;
            state      <= S_RESP;
          end else begin
            wdog_cnt <= wdog_cnt + CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          if (res_ready) begin
            jobs_done <= jobs_done + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_fc_sched.sv
// Bench for bnn_fc_sched: transaction-level reference model, engine responder, directed and random traffic.
module tb_bnn_fc_sched;
  localparam int NUM_REQ = 4;
  localparam int VEC_W   = 400;
  localparam int OUT_W   = 10;
  localparam int WDOG    = 64;

  logic                       clk;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*VEC_W-1:0]   req_vector;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       fc_in_valid;
  logic [VEC_W-1:0]           fc_vector;
  logic                       fc_ready;
  logic                       fc_busy;
  logic                       fc_out_valid;
  logic [OUT_W-1:0]           fc_out_vector;
  logic                       res_valid;
  logic                       res_ready;
  logic [OUT_W-1:0]           res_vector;
  logic [$clog2(NUM_REQ)-1:0] res_id;
  logic                       res_err;
  logic [15:0]                jobs_done;

  bnn_fc_sched #(.NUM_REQ(NUM_REQ), .VEC_W(VEC_W), .OUT_W(OUT_W), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_vector(req_vector), .req_ready(req_ready),
    .fc_in_valid(fc_in_valid), .fc_vector(fc_vector), .fc_ready(fc_ready), .fc_busy(fc_busy),
    .fc_out_valid(fc_out_valid), .fc_out_vector(fc_out_vector), .res_valid(res_valid),
    .res_ready(res_ready), .res_vector(res_vector), .res_id(res_id), .res_err(res_err),
    .jobs_done(jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stand-in engine result: all-ones frame maps to 10'h3FF.
  function automatic logic [OUT_W-1:0] fcalc(input logic [VEC_W-1:0] v);
    return v[OUT_W-1:0] ^ ~v[VEC_W-1 -: OUT_W];
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int i = 0; i < NUM_REQ; i++) begin
      int k = (p + i) % NUM_REQ;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [VEC_W-1:0] rnd_vec();
    logic [VEC_W-1:0] v = '0;
    for (int i = 0; i < 13; i++) v = (v << 32) | VEC_W'($urandom);
    return v;
  endfunction

  // ---------------- reference model: one job record, checked every cycle ----------------
  int               cyc = 0;
  bit               m_job, m_iss, m_res, m_err;
  int               m_ptr, m_id, m_icyc;
  logic [VEC_W-1:0] m_vec;
  logic [15:0]      m_done;
  logic [NUM_REQ-1:0] e_rdy;
  logic             e_iv, e_rv;
  int               g;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      m_job = 0; m_iss = 0; m_res = 0; m_err = 0; m_ptr = 0; m_done = '0;
    end else begin
      e_rdy = '0; e_iv = 1'b0; e_rv = 1'b0; g = -1;
      if (!m_job) begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) e_rdy[g] = 1'b1;
      end else if (!m_iss) e_iv = fc_ready && !fc_busy;
      else if (m_res) e_rv = 1'b1;

      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("fc_in_valid", 64'(fc_in_valid), 64'(e_iv));
      chk("res_valid", 64'(res_valid), 64'(e_rv));
      chk("jobs_done", 64'(jobs_done), 64'(m_done));
      if (m_job && !m_res) begin
        total++;
        if (fc_vector !== m_vec) begin
          bad++;
          $display("FAIL fc_vector actual=%0h required=%0h", fc_vector[63:0], m_vec[63:0]);
        end
      end
      if (e_rv) begin
        chk("res_vector", 64'(res_vector), m_err ? 64'd0 : 64'(fcalc(m_vec)));
        chk("res_id", 64'(res_id), 64'(m_id));
        chk("res_err", 64'(res_err), 64'(m_err));
      end

      if (!m_job) begin
        if (g >= 0) begin
          m_job = 1; m_iss = 0; m_res = 0; m_id = g;
          m_vec = req_vector[g*VEC_W +: VEC_W];
          m_ptr = (g + 1) % NUM_REQ;
        end
      end else if (!m_iss) begin
        if (e_iv) begin m_iss = 1; m_icyc = cyc; end
      end else if (!m_res) begin
        if (fc_out_valid) begin m_res = 1; m_err = 0; end
`ifdef BNN_FC_SCHED_WDOG_EN
        else if (cyc - m_icyc == WDOG - 1) begin m_res = 1; m_err = 1; end
`endif
      end else if (res_ready) begin
        m_done = m_done + 16'd1;
        m_job = 0; m_iss = 0; m_res = 0;
      end
    end
  end

  // ---------------- stimulus: requesters, engine responder, sink ----------------
  bit               rand_mode = 0;
  int               eng_lat = 4;
  int               eng_cnt = 0;
  logic [VEC_W-1:0] eng_vec, iss_vec;
  logic             iss;
  logic [NUM_REQ-1:0] acc;

  task automatic step();
    @(negedge clk);
    iss = fc_in_valid; iss_vec = fc_vector; acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    fc_out_valid = 1'b0;
    if (reset) eng_cnt = 0;
    else begin
      if (iss) begin
        eng_cnt = rand_mode ? int'($urandom_range(1, 6)) : eng_lat;
        eng_vec = iss_vec;
      end
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin fc_out_valid = 1'b1; fc_out_vector = fcalc(eng_vec); end
      end else if (!iss && rand_mode && $urandom_range(0, 19) == 0) begin
        fc_out_valid = 1'b1; fc_out_vector = OUT_W'($urandom);
      end
    end
    fc_busy = (eng_cnt > 0) || (rand_mode && $urandom_range(0, 15) < 3);
    if (rand_mode) begin
      fc_ready  = ($urandom_range(0, 99) < 85);
      res_ready = ($urandom_range(0, 99) < 70);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (acc[k] || !req_valid[k]) begin
          if ($urandom_range(0, 9) < 6) begin
            req_valid[k] = 1'b1;
            req_vector[k*VEC_W +: VEC_W] = rnd_vec();
          end else req_valid[k] = 1'b0;
        end else if ($urandom_range(0, 31) == 0) req_valid[k] = 1'b0;
      end
    end
  endtask

  int n, n_iss, id0, jobs0;
  logic [OUT_W-1:0] vec0;
  bit   ok;
  int   grants[6];
  int   exp_order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1; req_valid = '0; req_vector = '0; fc_ready = 1'b1; fc_busy = 1'b0;
    fc_out_valid = 1'b0; fc_out_vector = '0; res_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_fc_in_valid", 64'(fc_in_valid), 64'd0);
    chk("rst_fc_vector", 64'(fc_vector == '0), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res", 64'({res_vector, res_id, res_err}), 64'd0);
    chk("rst_jobs_done", 64'(jobs_done), 64'd0);

    // single job on requester 2, nominal 4-cycle engine
    req_valid = 4'b0100; req_vector[2*VEC_W +: VEC_W] = '1; eng_lat = 4;
    #1 chk("t1_req_ready", 64'(req_ready), 64'h4);
    step(); req_valid = '0;
    #1 chk("t1_issue", 64'(fc_in_valid), 64'd1);
    n = 1; n_iss = 1;
    while (!res_valid && n < 30) begin step(); #1; n++; n_iss += int'(fc_in_valid); end
    chk("t1_latency", 64'(n), 64'd6);
    chk("t1_res_vector", 64'(res_vector), 64'h3FF);
    chk("t1_res_id", 64'(res_id), 64'd2);
    step(); #1;
    chk("t1_jobs_done", 64'(jobs_done), 64'd1);
    chk("t1_issue_count", 64'(n_iss), 64'd1);

    // all requesters valid from a fresh rr pointer
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) req_vector[k*VEC_W +: VEC_W] = rnd_vec();
    req_valid = '1; n = 0; n_iss = 0;
    for (int c = 0; c < 300 && n < 6; c++) begin
      #1;
      if (req_ready != '0) begin grants[n] = oh2i(req_ready); n++; end
      n_iss += int'(fc_in_valid);
      if (n < 6) step();
    end
    chk("t2_grants", 64'(n), 64'd6);
    for (int i = 0; i < 6; i++) chk("t2_order", 64'(grants[i]), 64'(exp_order[i]));
    chk("t2_issue_count", 64'(n_iss), 64'd5);

    // result backpressure
    res_ready = 1'b0; n = 0;
    while (!res_valid && n < 50) begin step(); #1; n++; end
    chk("t3_res_seen", 64'(res_valid), 64'd1);
    id0 = int'(res_id); vec0 = res_vector; ok = 1;
    for (int i = 0; i < 20; i++) begin
      step(); #1;
      if (!res_valid || res_id != id0[1:0] || res_vector != vec0 || req_ready != '0) ok = 0;
    end
    chk("t3_stable", 64'(ok), 64'd1);
    res_ready = 1'b1; step(); #1;
    chk("t3_next_grant", 64'(req_ready), 64'(4'b0001 << ((id0 + 1) % NUM_REQ)));

    // engine not ready after accept
    req_valid = '0; repeat (30) step();
    req_valid = 4'b0010; fc_ready = 1'b0;
    #1 chk("t4_grant", 64'(req_ready), 64'h2);
    step(); req_valid = '0; ok = 1;
    for (int i = 0; i < 5; i++) begin #1; if (fc_in_valid) ok = 0; step(); end
    chk("t4_held", 64'(ok), 64'd1);
    fc_ready = 1'b1;
    #1 chk("t4_issue", 64'(fc_in_valid), 64'd1);
    repeat (20) step();

    // reset while waiting on the engine
    req_valid = 4'b1000; eng_lat = 10;
    step(); req_valid = '0; step(); step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    #1;
    chk("t5_outputs", 64'({req_ready, fc_in_valid, res_valid, res_err}), 64'd0);
    chk("t5_fc_vector", 64'(fc_vector == '0), 64'd1);
    chk("t5_res", 64'({res_vector, res_id}), 64'd0);
    chk("t5_jobs_done", 64'(jobs_done), 64'd0);
    ok = 1;
    for (int i = 0; i < 15; i++) begin step(); #1; if (res_valid) ok = 0; end
    chk("t5_dropped", 64'(ok), 64'd1);
    req_valid = '1;
    #1 chk("t5_rr_ptr0", 64'(req_ready), 64'h1);

    // randomized traffic against the model
    jobs0 = int'(jobs_done);
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0; req_valid = '0; fc_ready = 1'b1; res_ready = 1'b1; fc_busy = 1'b0;
    repeat (40) step();
    #1;
    total++;
    if (int'(jobs_done) - jobs0 < 100) begin
      bad++;
      $display("FAIL rand_progress actual=%0d required>=100", int'(jobs_done) - jobs0);
    end

`ifdef BNN_FC_SCHED_WDOG_EN
    // silent engine: watchdog completes the job, late result ignored
    reset = 1'b1; step(); reset = 1'b0;
    req_valid = 4'b0001; eng_lat = 70; res_ready = 1'b0;
    #1 chk("t6_grant", 64'(req_ready), 64'h1);
    step(); req_valid = '0;
    #1 chk("t6_issue", 64'(fc_in_valid), 64'd1);
    n = 0;
    while (!res_valid && n < 100) begin step(); n++; #1; end
    chk("t6_expiry", 64'(n), 64'd64);
    chk("t6_err", 64'({res_err, res_vector}), 64'(1 << OUT_W));
    repeat (12) step();
    #1 chk("t6_late_ignored", 64'({res_valid, res_err, res_vector}), 64'(3 << OUT_W));
    res_ready = 1'b1; step(); #1;
    chk("t6_jobs_done", 64'(jobs_done), 64'd1);
    repeat (10) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
